vec_decode_sequencer: RTL
=========================

Name: vec_decode_sequencer

Overview:
- Registered, parametrised main decoder for the SIMD AES pipeline's Decode stage.
- Maps Opcode/Func to datapath control signals, with one-cycle latency.
- Vector memory instructions (ldrv/strv) whose vector is wider than the memory port are split into VEC_BEATS sequential beats; fetch/decode is stalled until the last beat issues.
- Sits between the IF/ID register and the ID/EX register, and obeys the hazard unit's stall/flush.

Parameters:
- VEC_WIDTH, 128: vector register width in bits.
- MEM_WIDTH, 32: data memory port width in bits. VEC_WIDTH must be an integer multiple of MEM_WIDTH.
- VEC_BEATS (localparam), VEC_WIDTH/MEM_WIDTH: beats per vector memory access.
- BW (localparam), max(1, $clog2(VEC_BEATS)): beat counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- valid_i  in  1  instruction present in IF/ID.
- Opcode  in  6  instruction opcode.
- Func  in  3  function field.
- stall_i  in  1  hazard-unit stall; holds all state.
- flush_i  in  1  hazard-unit flush; kills the current or in-flight instruction.
- ready_o  out  1  decoder can accept a new instruction; 0 stalls fetch.
- valid_o  out  1  registered controls are valid.
- Branch, RegW, RegWV, ALUOp, MemW, MemSrc, MemtoReg, ALUSrc  out  1 each  registered controls.
- RegSrc, ImmSrc  out  2 each  registered controls.
- beat_o  out  BW  current beat index, used as the address offset (×MEM_WIDTH/8).
- last_beat_o  out  1  final beat of the instruction; 1 for every single-beat instruction.
- illegal_o  out  1  see Optional Feature.

Behaviour:
- Reset: FSM=IDLE. ready_o=1. valid_o, all controls, beat_o, last_beat_o and illegal_o are 0.
- Control outputs are fully specified. There are no X values: every unlisted signal is 0.
- Decode table (listed signals are 1 unless a value is given):
  - 000000 scalar R: RegW, ALUOp. If Func[1:0]=11 (sll/slr), also ALUSrc and ImmSrc=11.
  - 100000 vector R: RegWV, ALUOp, MemtoReg.
  - 0010xx immediate: RegW, ALUOp, ALUSrc, ImmSrc=00.
  - 011000 str: RegSrc=01, MemW, ALUSrc.
  - 011001 ldr: RegW, MemtoReg, ALUSrc.
  - 111000 strv: RegSrc=01, MemW, MemSrc, ALUSrc. Multi-beat.
  - 111001 ldrv: RegWV, MemSrc, MemtoReg, ALUSrc. Multi-beat. RegWV is asserted only on the last beat.
  - 001100 beq and 001101 bgt: Branch, RegSrc=01, ALUOp.
  - 000100 b: Branch.
  - Any other opcode: illegal, decodes as NOP (all controls 0).
- Precedence each clock: rst > flush_i > stall_i > normal operation.
- IDLE state:
  - If valid_i and !stall_i: register the decoded controls next edge, valid_o=1, beat_o=0.
  - Multi-beat op with VEC_BEATS>1: go to VBEAT, ready_o=0, last_beat_o=0.
  - Otherwise: stay in IDLE, last_beat_o=1.
  - If !valid_i: valid_o=0 and all controls 0.
- VBEAT state:
  - Each non-stalled cycle: beat_o increments and the controls are held.
  - When beat_o reaches VEC_BEATS-1: last_beat_o=1 and ready_o=1.
  - Next non-stalled edge after that: return to IDLE and accept valid_i as in IDLE.
  - Beat index never wraps inside an instruction.
- VEC_BEATS=1: multi-beat ops behave as single-beat ops and VBEAT is unreachable.
- stall_i=1: every register, including FSM and beat_o, holds. ready_o holds.
- flush_i=1 in any state:
  - Next edge: valid_o=0, all controls 0, beat_o=0, FSM=IDLE, ready_o=1.
  - Flush mid-burst abandons the remaining beats. Beats already issued are not undone; a partial strv is accepted architecturally.
- Simultaneous flush_i and stall_i: flush wins.
- Reset asserted mid-burst: immediate return to reset values (asynchronous).

Optional Feature:
- Macro DECODE_ILLEGAL_TRAP_EN.
- Defined:
  - illegal_o is registered alongside the controls and pulses 1 with valid_o for an illegal opcode.
  - A sticky internal flag then holds ready_o=0 until rst.
  - The controls remain NOP.
- Undefined: illegal_o is tied to 0, and illegal opcodes retire silently as NOP.

Decomposition:
- Package decode_pkg holds:
  - opcode localparams (OP_RTYPE, OP_VRTYPE, OP_IMM, OP_STR, OP_LDR, OP_STRV, OP_LDRV, OP_BEQ, OP_BGT, OP_B);
  - ImmSrc and RegSrc encodings;
  - a packed struct ctrl_t for the control bundle;
  - the FSM enum {IDLE, VBEAT}.
- One natural sub-module: decode_lut, a purely combinational Opcode/Func -> ctrl_t plus is_vmem/is_illegal. The parent holds the FSM, beat counter and output register.

Test Plan:
- Reset, then ldr (011001) with valid_i=1 → one cycle later: valid_o=1, RegW=1, MemtoReg=1, ALUSrc=1, last_beat_o=1, ready_o=1.
- VEC_WIDTH=128, MEM_WIDTH=32, ldrv (111001) → four cycles with MemSrc=1 and beat_o=0,1,2,3; ready_o=0 for beats 0–2; RegWV=1 only at beat_o=3.
- strv with stall_i high for 2 cycles during beat 1 → beat_o holds at 1 for 3 cycles, then 2,3; MemW=1 throughout.
- flush_i at beat 2 of strv → next cycle valid_o=0, MemW=0, ready_o=1, FSM=IDLE; the following beq yields Branch=1, RegSrc=01.
- Opcode 010101 → all controls 0. With DECODE_ILLEGAL_TRAP_EN: illegal_o pulses once and ready_o stays 0 until rst.
- sll (000000, Func=011) → ImmSrc=11, ALUSrc=1. add (Func=000) → ALUSrc=0, ImmSrc=00.

Source files
------------

// File: rtl/vec_decode_sequencer_pkg.sv
// decode_pkg: opcodes, field encodings, control bundle and FSM states for the vector decode sequencer.
package decode_pkg;
  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_VRTYPE = 6'b100000;
  localparam logic [5:0] OP_IMM    = 6'b001000;
  localparam logic [5:0] OP_STR    = 6'b011000;
  localparam logic [5:0] OP_LDR    = 6'b011001;
  localparam logic [5:0] OP_STRV   = 6'b111000;
  localparam logic [5:0] OP_LDRV   = 6'b111001;
  localparam logic [5:0] OP_BEQ    = 6'b001100;
  localparam logic [5:0] OP_BGT    = 6'b001101;
  localparam logic [5:0] OP_B      = 6'b000100;
  localparam logic [1:0] IMM_ARITH = 2'b00;
  localparam logic [1:0] IMM_SHIFT = 2'b11;
  localparam logic [1:0] REG_DEF   = 2'b00;
  localparam logic [1:0] REG_RD    = 2'b01;
  typedef struct packed {
    logic       branch;
    logic       reg_w;
    logic       reg_wv;
    logic       alu_op;
    logic       mem_w;
    logic       mem_src;
    logic       mem_to_reg;
    logic       alu_src;
    logic [1:0] reg_src;
    logic [1:0] imm_src;
  } ctrl_t;
  typedef enum logic {IDLE, VBEAT} state_t;
endpackage

// File: rtl/vec_decode_sequencer_lut.sv
// decode_lut: combinational Opcode/Func to control bundle, plus vector-memory and illegal flags.
module decode_lut
  import decode_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [2:0] func_i,
  output ctrl_t      ctrl_o,
  output logic       is_vmem_o,
  output logic       is_illegal_o
);
  always_comb begin
    ctrl_o = '0;
    is_vmem_o = 1'b0;
    is_illegal_o = 1'b0;
    case (op_i)
      OP_RTYPE: begin
        ctrl_o.reg_w = 1'b1;
        ctrl_o.alu_op = 1'b1;
        ctrl_o.alu_src = func_i inside {3'b011, 3'b111};
        ctrl_o.imm_src = ctrl_o.alu_src ? IMM_SHIFT : IMM_ARITH;
      end
      OP_VRTYPE: begin
        ctrl_o.reg_wv = 1'b1;
        ctrl_o.alu_op = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
      end
      OP_STR: begin
        ctrl_o.reg_src = REG_RD;
        ctrl_o.mem_w = 1'b1;
        ctrl_o.alu_src = 1'b1;
      end
      OP_LDR: begin
        ctrl_o.reg_w = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.alu_src = 1'b1;
      end
      OP_STRV: begin
        ctrl_o.reg_src = REG_RD;
        ctrl_o.mem_w = 1'b1;
        ctrl_o.mem_src = 1'b1;
        ctrl_o.alu_src = 1'b1;
        is_vmem_o = 1'b1;
      end
      OP_LDRV: begin
        ctrl_o.reg_wv = 1'b1;
        ctrl_o.mem_src = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.alu_src = 1'b1;
        is_vmem_o = 1'b1;
      end
      OP_BEQ, OP_BGT: begin
        ctrl_o.branch = 1'b1;
        ctrl_o.reg_src = REG_RD;
        ctrl_o.alu_op = 1'b1;
      end
      OP_B: ctrl_o.branch = 1'b1;
      default: begin
        if (op_i[5:2] == OP_IMM[5:2]) begin
          ctrl_o.reg_w = 1'b1;
          ctrl_o.alu_op = 1'b1;
          ctrl_o.alu_src = 1'b1;
          ctrl_o.imm_src = IMM_ARITH;
        end else begin
          is_illegal_o = 1'b1;
        end
      end
    endcase
  end
endmodule

// File: rtl/vec_decode_sequencer.sv
// vec_decode_sequencer: registered decoder splitting wide vector loads/stores into memory-port beats.
// Optional macro DECODE_ILLEGAL_TRAP_EN: flag illegal opcodes and hold ready_o low until reset.
module vec_decode_sequencer
  import decode_pkg::*;
#(
  parameter int VEC_WIDTH = 128,
  parameter int MEM_WIDTH = 32,
  localparam int VEC_BEATS = VEC_WIDTH / MEM_WIDTH,
  localparam int BW = (VEC_BEATS > 1) ? $clog2(VEC_BEATS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid_i,
  input  logic [5:0]    Opcode,
  input  logic [2:0]    Func,
  input  logic          stall_i,
  input  logic          flush_i,
  output logic          ready_o,
  output logic          valid_o,
  output logic          Branch,
  output logic          RegW,
  output logic          RegWV,
  output logic          ALUOp,
  output logic          MemW,
  output logic          MemSrc,
  output logic          MemtoReg,
  output logic          ALUSrc,
  output logic [1:0]    RegSrc,
  output logic [1:0]    ImmSrc,
  output logic [BW-1:0] beat_o,
  output logic          last_beat_o,
  output logic          illegal_o
);
  localparam logic [BW-1:0] LAST = BW'(VEC_BEATS - 1);
  localparam bit MULTI = VEC_BEATS > 1;
`ifdef DECODE_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  ctrl_t dec, ctrl_q, ctrl_d;
  logic is_vmem, is_ill, vm;
  state_t state_q, state_d;
  logic [BW-1:0] beat_q, beat_d;
  logic last_q, last_d, valid_q, valid_d, ready_q, ready_d, ill_q, ill_d, trap_q, trap_d;
  decode_lut u_lut (
    .op_i        (Opcode),
    .func_i      (Func),
    .ctrl_o      (dec),
    .is_vmem_o   (is_vmem),
    .is_illegal_o(is_ill)
  );
  assign vm = is_vmem & MULTI;
  always_comb begin
    state_d = state_q;
    ctrl_d = ctrl_q;
    beat_d = beat_q;
    last_d = last_q;
    valid_d = valid_q;
    ready_d = ready_q;
    ill_d = ill_q;
    trap_d = trap_q;
    if (flush_i) begin
      state_d = IDLE;
      ctrl_d = '0;
      beat_d = '0;
      last_d = 1'b0;
      valid_d = 1'b0;
      ready_d = !trap_q;
      ill_d = 1'b0;
    end else if (!stall_i) begin
      ill_d = 1'b0;
      if (state_q == VBEAT && !ready_q) begin
        beat_d = beat_q + 1'b1;
        last_d = beat_d == LAST;
        ready_d = last_d;
      end else if (ready_q && valid_i) begin
        state_d = vm ? VBEAT : IDLE;
        ctrl_d = dec;
        beat_d = '0;
        last_d = !vm;
        valid_d = 1'b1;
        ill_d = TRAP & is_ill;
        trap_d = trap_q | ill_d;
        ready_d = !vm && !trap_d;
      end else begin
        state_d = IDLE;
        ctrl_d = '0;
        beat_d = '0;
        last_d = 1'b0;
        valid_d = 1'b0;
        ready_d = !trap_q;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ctrl_q <= '0;
      beat_q <= '0;
      last_q <= 1'b0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      ill_q <= 1'b0;
      trap_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ctrl_q <= ctrl_d;
      beat_q <= beat_d;
      last_q <= last_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
      ill_q <= ill_d;
      trap_q <= trap_d;
    end
  end
  // ldrv writes the vector register only once the final beat has landed
  assign RegWV = ctrl_q.reg_wv & last_q;
  assign Branch = ctrl_q.branch;
  assign RegW = ctrl_q.reg_w;
  assign ALUOp = ctrl_q.alu_op;
  assign MemW = ctrl_q.mem_w;
  assign MemSrc = ctrl_q.mem_src;
  assign MemtoReg = ctrl_q.mem_to_reg;
  assign ALUSrc = ctrl_q.alu_src;
  assign RegSrc = ctrl_q.reg_src;
  assign ImmSrc = ctrl_q.imm_src;
  assign ready_o = ready_q;
  assign valid_o = valid_q;
  assign beat_o = beat_q;
  assign last_beat_o = last_q;
  assign illegal_o = ill_q;
endmodule
